// File: rtl/target_uart_reporter_if.sv
// Bundle between the red-tracker outputs and the UART reporter.
// The tracker/top level (master) drives the frame and target inputs.
// The reporter (slave) drives the serial line and the selection status.
interface target_uart_reporter_if;
  logic         v_sync;
  logic [159:0] aim_x_all;
  logic [159:0] aim_y_all;
  logic [15:0]  aim_detected_all;
  logic         target_off;
  logic         tx;
  logic         busy;
  logic         sel_valid;
  logic [3:0]   sel_idx;

  modport master (
    output v_sync, aim_x_all, aim_y_all, aim_detected_all, target_off,
    input  tx, busy, sel_valid, sel_idx
  );

  modport slave (
    input  v_sync, aim_x_all, aim_y_all, aim_detected_all, target_off,
    output tx, busy, sel_valid, sel_idx
  );
endinterface

// File: rtl/target_uart_reporter.sv
// Per-frame target reporter.
// On each v_sync falling edge seen while idle, it snapshots the 16 tracker
// slots and scans them one per cycle for the detected target nearest the aim
// centre (Manhattan distance; ties keep the lower slot). It then sends a
// 7-byte 8N1 packet (header, status, x, y, XOR checksum) to the motor MCU.
module target_uart_reporter #(
  parameter int CLK_HZ   = 25_000_000,
  parameter int BAUD     = 115_200,
  parameter int CENTER_X = 320,
  parameter int CENTER_Y = 240
) (
  input  logic                 clk,
  input  logic                 reset,
  target_uart_reporter_if.slave bus
);

  localparam int               BIT_CYC   = CLK_HZ / BAUD;
  localparam int               BCW       = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [BCW-1:0]   BAUD_LAST = BCW'(BIT_CYC - 1);
  localparam logic [9:0]       CX        = 10'(CENTER_X);
  localparam logic [9:0]       CY        = 10'(CENTER_Y);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNAP,
    S_SCAN,
    S_LOAD,
    S_SEND
  } state_t;

  // Control state
  state_t         state_q, state_d;
  logic           vsync_dly_q;
  logic [3:0]     scan_q, scan_d;
  logic [BCW-1:0] baud_q, baud_d;
  logic [3:0]     bit_q, bit_d;
  logic [2:0]     byte_q, byte_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           sel_valid_q, sel_valid_d;
  logic [3:0]     sel_idx_q, sel_idx_d;
  logic           best_vld_q, best_vld_d;
  logic [3:0]     best_idx_q, best_idx_d;

  // Datapath state (no reset: always written before it is consumed)
  logic [159:0]   shd_x_q, shd_y_q;
  logic [15:0]    shd_det_q;
  logic           shd_off_q;
  logic [10:0]    best_dist_q;
  logic [9:0]     best_x_q, best_y_q;
  logic [9:0]     pkt_x_q, pkt_y_q;
  logic           pkt_off_q;

  // Scan datapath signals
  logic           frame_evt;
  logic [7:0]     slot_base;
  logic [9:0]     cur_x, cur_y;
  logic [10:0]    cur_dist;
  logic           cur_cand;
  logic           cur_better;

  // Packet assembly
  logic [7:0]     pkt_b [0:7];
  logic [3:0]     data_pos;

  // |v - c| for 10-bit unsigned coordinates; fits in 10 bits, returned as 11
  function automatic logic [10:0] abs_diff(input logic [9:0] v, input logic [9:0] c);
    logic signed [11:0] diff;
    diff = $signed({2'b00, v}) - $signed({2'b00, c});
    return (diff < 0) ? 11'(-diff) : 11'(diff);
  endfunction

  // Serial bit for a given byte/bit position: start, 8 data LSB-first, stop
  function automatic logic uart_bit(input logic [7:0] data, input logic [3:0] pos);
    logic [3:0] dpos;
    dpos = pos - 4'd1;
    if (pos == 4'd0) return 1'b0;
    if (pos >= 4'd9) return 1'b1;
    return data[dpos[2:0]];
  endfunction

  assign frame_evt  = (state_q == S_IDLE) && vsync_dly_q && !bus.v_sync;
  assign slot_base  = {4'd0, scan_q} * 8'd10;
  assign cur_x      = shd_x_q[slot_base +: 10];
  assign cur_y      = shd_y_q[slot_base +: 10];
  // Max 703 + 783 = 1486, so 11 bits never overflow
  assign cur_dist   = abs_diff(cur_x, CX) + abs_diff(cur_y, CY);
  assign cur_cand   = shd_det_q[scan_q] && !shd_off_q;
  // Strictly smaller distance only, so equal distances keep the earlier slot
  assign cur_better = cur_cand && (!best_vld_q || (cur_dist < best_dist_q));

  // Build the seven packet bytes from the values latched at LOAD
  always_comb begin
    pkt_b[0] = 8'hAA;
    pkt_b[1] = {sel_idx_q, 2'b00, pkt_off_q, sel_valid_q};
    pkt_b[2] = {6'b0, pkt_x_q[9:8]};
    pkt_b[3] = pkt_x_q[7:0];
    pkt_b[4] = {6'b0, pkt_y_q[9:8]};
    pkt_b[5] = pkt_y_q[7:0];
    pkt_b[6] = pkt_b[1] ^ pkt_b[2] ^ pkt_b[3] ^ pkt_b[4] ^ pkt_b[5];
    pkt_b[7] = 8'hFF;
  end

  // FSM next state, scan/baud/bit/byte counters, busy and serial line
  always_comb begin
    state_d  = state_q;
    scan_d   = scan_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    busy_d   = 1'b0;
    tx_d     = 1'b1;
    data_pos = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (frame_evt) state_d = S_SNAP;
      end
      S_SNAP: begin
        state_d = S_SCAN;
        scan_d  = 4'd0;
      end
      S_SCAN: begin
        scan_d = scan_q + 4'd1;
        if (scan_q == 4'd15) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_SEND;
        baud_d  = '0;
        bit_d   = 4'd0;
        byte_d  = 3'd0;
      end
      S_SEND: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            bit_d = 4'd0;
            if (byte_q == 3'd6) begin
              state_d = S_IDLE;
              byte_d  = 3'd0;
            end else begin
              byte_d = byte_q + 3'd1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + BCW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_SCAN) || (state_d == S_LOAD) || (state_d == S_SEND);
    // tx is registered: drive the bit that the next cycle's counters point at
    if (state_d == S_SEND) begin
      data_pos = bit_d;
      tx_d     = uart_bit(pkt_b[byte_d], data_pos);
    end
  end

  // Selection tracking during SCAN and publication at LOAD
  always_comb begin
    sel_valid_d = sel_valid_q;
    sel_idx_d   = sel_idx_q;
    best_vld_d  = best_vld_q;
    best_idx_d  = best_idx_q;
    case (state_q)
      S_SNAP: best_vld_d = 1'b0;
      S_SCAN: begin
        if (cur_better) begin
          best_vld_d = 1'b1;
          best_idx_d = scan_q;
        end
      end
      S_LOAD: begin
        sel_valid_d = best_vld_q;
        sel_idx_d   = best_vld_q ? best_idx_q : 4'd0;
      end
      default: ;
    endcase
  end

  // Control registers; reset aborts any packet and parks the line high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      vsync_dly_q <= 1'b1;
      scan_q      <= 4'd0;
      baud_q      <= '0;
      bit_q       <= 4'd0;
      byte_q      <= 3'd0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      sel_valid_q <= 1'b0;
      sel_idx_q   <= 4'd0;
      best_vld_q  <= 1'b0;
      best_idx_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      vsync_dly_q <= bus.v_sync;
      scan_q      <= scan_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      sel_valid_q <= sel_valid_d;
      sel_idx_q   <= sel_idx_d;
      best_vld_q  <= best_vld_d;
      best_idx_q  <= best_idx_d;
    end
  end

  // Snapshot, best-candidate and packet payload registers
  always_ff @(posedge clk) begin
    if (state_q == S_SNAP) begin
      shd_x_q   <= bus.aim_x_all;
      shd_y_q   <= bus.aim_y_all;
      shd_det_q <= bus.aim_detected_all;
      shd_off_q <= bus.target_off;
    end
    if ((state_q == S_SCAN) && cur_better) begin
      best_dist_q <= cur_dist;
      best_x_q    <= cur_x;
      best_y_q    <= cur_y;
    end
    if (state_q == S_LOAD) begin
      pkt_x_q   <= best_vld_q ? best_x_q : 10'd0;
      pkt_y_q   <= best_vld_q ? best_y_q : 10'd0;
      pkt_off_q <= shd_off_q;
    end
  end

  assign bus.tx        = tx_q;
  assign bus.busy      = busy_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.sel_idx   = sel_idx_q;

endmodule

// File: tb/tb_target_uart_reporter.sv
// Bench for target_uart_reporter: directed and random frames, a reference
// model of the nearest-target rule and packet format, and a UART decoder
// that pops expected bytes from a queue as the DUT transmits them.
module tb_target_uart_reporter;

  localparam int CLK_HZ = 25_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int B      = CLK_HZ / BAUD;
  localparam int CX     = 320;
  localparam int CY     = 240;

  logic clk = 1'b0;
  logic reset;

  target_uart_reporter_if bus();

  target_uart_reporter #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .CENTER_X(CX), .CENTER_Y(CY)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_run  = 0;
  int         n_fail = 0;
  int         epoch  = 0;
  logic [7:0] exp_q[$];

  int sx[16];
  int sy[16];
  bit sdet[16];
  bit soff;
  bit prev_v, cur_v;
  int prev_idx, cur_idx;

  task automatic check(input string name, input int got, input int want);
    n_run++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, got, got, want, want, cyc);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: nearest detected slot, then the 7-byte packet.
  // Result: bytes k at [k*8 +: 8], valid at [56], index at [63:60].
  function automatic logic [63:0] model();
    logic [63:0] r;
    int best, bd, d, xv, yv, idx;
    int b[7];
    best = -1;
    bd   = 0;
    for (int i = 0; i < 16; i++) begin
      if (sdet[i] && !soff) begin
        d = iabs(sx[i] - CX) + iabs(sy[i] - CY);
        if (best < 0 || d < bd) begin
          best = i;
          bd   = d;
        end
      end
    end
    idx  = (best >= 0) ? best : 0;
    xv   = (best >= 0) ? sx[best] : 0;
    yv   = (best >= 0) ? sy[best] : 0;
    b[0] = 'hAA;
    b[1] = idx * 16 + (soff ? 2 : 0) + ((best >= 0) ? 1 : 0);
    b[2] = xv / 256;
    b[3] = xv % 256;
    b[4] = yv / 256;
    b[5] = yv % 256;
    b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
    r = '0;
    for (int k = 0; k < 7; k++) r[k*8 +: 8] = b[k][7:0];
    r[56]    = (best >= 0);
    r[63:60] = idx[3:0];
    return r;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < 16; i++) begin
      bus.aim_x_all[i*10 +: 10]  = sx[i][9:0];
      bus.aim_y_all[i*10 +: 10]  = sy[i][9:0];
      bus.aim_detected_all[i]    = sdet[i];
    end
    bus.target_off = soff;
  endtask

  task automatic clear_slots();
    for (int i = 0; i < 16; i++) begin
      sx[i]   = 0;
      sy[i]   = 0;
      sdet[i] = 1'b0;
    end
    soff = 1'b0;
  endtask

  task automatic random_slots(input int det_mod);
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        sx[i] = 312 + int'($urandom_range(0, 16));
        sy[i] = 232 + int'($urandom_range(0, 16));
      end else begin
        sx[i] = int'($urandom_range(0, 1023));
        sy[i] = int'($urandom_range(0, 1023));
      end
      sdet[i] = ($urandom_range(0, det_mod) == 0);
    end
    soff = ($urandom_range(0, 7) == 0);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Apply inputs, queue the expected packet, fire one v_sync falling edge.
  task automatic start_frame(output int n);
    logic [63:0] m;
    drive_inputs();
    m = model();
    for (int k = 0; k < 7; k++) exp_q.push_back(m[k*8 +: 8]);
    cur_v   = m[56];
    cur_idx = int'(m[63:60]);
    @(posedge clk);
    #1;
    n = cyc;
    bus.v_sync = 1'b0;
    wait_cyc(n + 1);
    check("busy_in_snap", int'(bus.busy), 0);
    wait_cyc(n + 2);
    check("busy_rise", int'(bus.busy), 1);
    wait_cyc(n + 3);
    bus.v_sync = 1'b1;
  endtask

  task automatic check_start(input int n);
    wait_cyc(n + 18);
    check("sel_valid_hold", int'(bus.sel_valid), int'(prev_v));
    check("sel_idx_hold", int'(bus.sel_idx), prev_idx);
    check("tx_idle_before_start", int'(bus.tx), 1);
    wait_cyc(n + 19);
    check("sel_valid", int'(bus.sel_valid), int'(cur_v));
    check("sel_idx", int'(bus.sel_idx), cur_idx);
    check("tx_start_bit", int'(bus.tx), 0);
    prev_v   = cur_v;
    prev_idx = cur_idx;
  endtask

  task automatic check_end(input int n);
    while (bus.busy === 1'b1 && cyc < n + 19 + 70 * B + 100) begin
      @(posedge clk);
      #1;
    end
    check("busy_fall_cycle", cyc, n + 19 + 70 * B);
    check("busy_low", int'(bus.busy), 0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("busy_no_retrigger", int'(bus.busy), 0);
  endtask

  task automatic run_frame();
    int n;
    start_frame(n);
    check_start(n);
    check_end(n);
  endtask

  // UART decoder: samples mid-bit on the falling clock edge and scores bytes
  initial begin : monitor
    int s, s0, ep, mon_ep, bidx;
    logic [7:0] d, e;
    logic st, sp;
    s0 = 0;
    bidx = 0;
    mon_ep = 0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.tx === 1'b0) begin
        s  = cyc;
        ep = epoch;
        if (ep != mon_ep) begin
          bidx   = 0;
          mon_ep = ep;
        end
        repeat (B / 2) @(negedge clk);
        st = bus.tx;
        for (int j = 0; j < 8; j++) begin
          repeat (B) @(negedge clk);
          d[j] = bus.tx;
        end
        repeat (B) @(negedge clk);
        sp = bus.tx;
        if (ep == epoch) begin
          if (exp_q.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%02h with no packet pending at cycle %0d", d, s);
          end else begin
            e = exp_q.pop_front();
            n_run++;
            if (st !== 1'b0 || sp !== 1'b1 || d !== e) begin
              n_fail++;
              $display("FAIL uart_byte%0d: got 0x%02h start=%b stop=%b expected 0x%02h start=0 stop=1",
                       bidx, d, st, sp, e);
            end
            if (bidx == 0) begin
              s0 = s;
            end else begin
              check("byte_start_spacing", s - s0, bidx * 10 * B);
            end
            bidx = (bidx == 6) ? 0 : bidx + 1;
          end
        end else begin
          bidx = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n, bad;
    reset      = 1'b0;
    bus.v_sync = 1'b1;
    clear_slots();
    drive_inputs();
    prev_v   = 1'b0;
    prev_idx = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", int'(bus.tx), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_sel_valid", int'(bus.sel_valid), 0);
    check("rst_sel_idx", int'(bus.sel_idx), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);

    // Single target: expect AA 51 01 90 00 64 A4
    clear_slots();
    sx[5] = 400; sy[5] = 100; sdet[5] = 1'b1;
    run_frame();

    // Equal distances: slot 2 wins over slot 9, slot 0 far away
    clear_slots();
    sx[2] = 330; sy[2] = 240; sdet[2] = 1'b1;
    sx[9] = 310; sy[9] = 240; sdet[9] = 1'b1;
    sx[0] = 0;   sy[0] = 0;   sdet[0] = 1'b1;
    run_frame();

    // Nothing detected
    random_slots(3);
    soff = 1'b0;
    for (int i = 0; i < 16; i++) sdet[i] = 1'b0;
    run_frame();

    // All detected but tracker reports targets off
    random_slots(3);
    for (int i = 0; i < 16; i++) sdet[i] = 1'b1;
    soff = 1'b1;
    run_frame();

    // Second falling edge while busy must be ignored
    clear_slots();
    sx[11] = 700; sy[11] = 900; sdet[11] = 1'b1;
    start_frame(n);
    check_start(n);
    wait_cyc(n + 1000);
    bus.v_sync = 1'b0;
    wait_cyc(n + 1003);
    bus.v_sync = 1'b1;
    check_end(n);

    // Input change after the snapshot must not reach the packet
    clear_slots();
    sx[3] = 100; sy[3] = 200; sdet[3] = 1'b1;
    start_frame(n);
    wait_cyc(n + 5);
    for (int i = 0; i < 16; i++) bus.aim_x_all[i*10 +: 10] = 10'd320;
    bus.aim_detected_all = 16'hFFFF;
    check_start(n);
    check_end(n);

    // Random frames
    for (int f = 0; f < 12; f++) begin
      random_slots(2);
      run_frame();
    end
    check("queue_drained", exp_q.size(), 0);

    // Reset in the middle of byte 2 aborts the packet at once
    random_slots(1);
    soff = 1'b0;
    start_frame(n);
    check_start(n);
    wait_cyc(n + 19 + 25 * B + 7);
    #3;
    reset = 1'b0;
    epoch++;
    exp_q.delete();
    #1;
    check("midsend_rst_tx", int'(bus.tx), 1);
    check("midsend_rst_busy", int'(bus.busy), 0);
    check("midsend_rst_sel_valid", int'(bus.sel_valid), 0);
    check("midsend_rst_sel_idx", int'(bus.sel_idx), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    prev_v   = 1'b0;
    prev_idx = 0;
    bad = 0;
    repeat (10000) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.sel_valid !== 1'b0) bad++;
    end
    check("idle_after_reset", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/target_uart_reporter.md
# target_uart_reporter

Downstream consumer of the red-tracker outputs in the camera/VGA top level. Once per video frame, at the start of the v_sync pulse, it snapshots the 16 target slots and selects the detected target nearest screen centre (Manhattan distance). It then transmits a 6-byte coordinate packet over an 8N1 UART to the motor-control MCU, which drives the pan/tilt tracking motors.

## Interface
Parameters:
- CLK_HZ, 25_000_000, frequency of clk (pixel clock)
- BAUD, 115_200, UART bit rate; bit period BIT_CYC = CLK_HZ / BAUD (integer division, 217 by default)
- CENTER_X, 320, horizontal aim reference
- CENTER_Y, 240, vertical aim reference

Ports:
- clk  in  1  system/pixel clock; the only clock
- reset  in  1  asynchronous, active-low reset
- v_sync  in  1  VGA vertical sync (active-low pulse), synchronous to clk
- aim_x_all  in  16x10  packed target x coordinates, slot i at [i*10 +: 10]
- aim_y_all  in  16x10  packed target y coordinates
- aim_detected_all  in  16  per-slot valid flags
- target_off  in  1  tracker "all targets off" indication
- tx  out  1  UART serial output, idle high
- busy  out  1  high from snapshot until the stop bit of the last byte completes
- sel_valid  out  1  registered: last scan found a detected target
- sel_idx  out  4  registered: index of the selected slot

## Operation
- Frame event: v_sync_d is v_sync registered once; the event occurs when v_sync_d=1 and v_sync=0. The event is honoured only in IDLE. While busy, events are ignored, with no queueing.
- States: IDLE -> SNAP -> SCAN -> LOAD -> SEND -> IDLE.
- SNAP: latch all three arrays and target_off into shadow registers. Later input changes have no effect on the current packet.
- SCAN: 16 cycles, slot i=0..15, one slot per cycle.
  - dist = |x-CENTER_X| + |y-CENTER_Y|, computed 11 bits wide with no overflow.
  - A slot is a candidate only if its detected bit is 1.
  - The current best is replaced only on a strictly smaller dist, so ties keep the lower index.
  - If the snapshotted target_off=1, every slot is treated as undetected.
- LOAD: update sel_valid/sel_idx and build the packet.
  - If no candidate: sel_valid=0, sel_idx=0, x=y=0.
- Packet bytes, in order:
  - B0 = 0xAA
  - B1 = {sel_idx[3:0], 2'b00, off, sel_valid}
  - B2 = {6'b0, x[9:8]}
  - B3 = x[7:0]
  - B4 = {6'b0, y[9:8]}
  - B5 = y[7:0]
  - B6 = B1^B2^B3^B4^B5
- Bytes B0..B6 are sent, 7 bytes total. This supersedes the "6-byte" count in the summary paragraph.
- SEND: each byte is 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1). Each bit lasts exactly BIT_CYC cycles. Bytes are back-to-back with no idle gap.
- Reset (async, active-low) forces, from any state:
  - state IDLE, tx=1, busy=0, sel_valid=0, sel_idx=0
  - bit/byte/baud counters 0, v_sync_d=1
- Reset asserted mid-byte aborts the packet immediately (tx=1). No partial resume occurs after reset release.

## Timing
- Event detected in cycle N (combinational on v_sync_d/v_sync).
- N+1: SNAP; busy rises at the end of N+1.
- N+2..N+17: SCAN slots 0..15.
- N+18: LOAD; sel_valid/sel_idx are visible from N+19.
- The start bit of B0 drives tx beginning cycle N+19.
- busy falls in the cycle after B6's stop bit completes: cycle N+19+70*BIT_CYC.
- Total packet time is 70*217 = 15190 cycles, far less than one frame (~420k cycles). In normal operation no events are dropped.
- sel_valid/sel_idx hold their values until the next LOAD.

## Test plan
- Reset: hold reset=0 mid-SEND -> tx=1, busy=0, sel_valid=0 in the same cycle. After release with no v_sync edge, tx stays 1 for 10k cycles.
- Single target: slot 5 detected at (400,100), others clear; drive a v_sync 1->0.
  - Expect sel_idx=5, sel_valid=1 at N+19, tx start bit at N+19.
  - Decoded bytes: AA 51 01 90 00 64 A4.
- Nearest/tie: slot 2 at (330,240) and slot 9 at (310,240) (both dist 10), slot 0 at (0,0) -> sel_idx=2; B1=0x21.
- None / target_off: all detected=0 -> packet AA 00 00 00 00 00 00. With detected=16'hFFFF and target_off=1 -> AA 02 00 00 00 00 02, sel_valid=0.
- Event while busy: second v_sync falling edge 1000 cycles after the first -> ignored, exactly one 7-byte packet.
- Snapshot isolation: change aim_x_all at N+5 -> packet carries the N+1 values. Bit-width check: each bit lasts 217 cycles ±0.
